// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_pkg
//  Description : Shared definitions for the control sequencer: opcode values,
//                bus source codes, ALU operation codes, the step enumeration
//                and helpers that classify an opcode into an execution shape.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

    // Opcodes (ir[31:27]); 13-31 are unassigned and execute as NOP
    localparam logic [4:0] c_op_add  = 5'd0;
    localparam logic [4:0] c_op_sub  = 5'd1;
    localparam logic [4:0] c_op_and  = 5'd2;
    localparam logic [4:0] c_op_or   = 5'd3;
    localparam logic [4:0] c_op_ld   = 5'd4;
    localparam logic [4:0] c_op_st   = 5'd5;
    localparam logic [4:0] c_op_addi = 5'd6;
    localparam logic [4:0] c_op_mul  = 5'd7;
    localparam logic [4:0] c_op_div  = 5'd8;
    localparam logic [4:0] c_op_mfhi = 5'd9;
    localparam logic [4:0] c_op_mflo = 5'd10;
    localparam logic [4:0] c_op_nop  = 5'd11;
    localparam logic [4:0] c_op_halt = 5'd12;

    // Bus source codes; 0-15 select general registers R0-R15
    localparam logic [4:0] c_bus_hi     = 5'd16;
    localparam logic [4:0] c_bus_lo     = 5'd17;
    localparam logic [4:0] c_bus_zhigh  = 5'd18;
    localparam logic [4:0] c_bus_zlow   = 5'd19;
    localparam logic [4:0] c_bus_pc     = 5'd20;
    localparam logic [4:0] c_bus_mdr    = 5'd21;
    localparam logic [4:0] c_bus_inport = 5'd22;
    localparam logic [4:0] c_bus_c      = 5'd23;

    // ALU operation codes
    localparam logic [4:0] c_alu_add = 5'd0;
    localparam logic [4:0] c_alu_sub = 5'd1;
    localparam logic [4:0] c_alu_and = 5'd2;
    localparam logic [4:0] c_alu_or  = 5'd3;
    localparam logic [4:0] c_alu_mul = 5'd4;
    localparam logic [4:0] c_alu_div = 5'd5;
    localparam logic [4:0] c_alu_inc = 5'd6;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // Execution shape of an instruction after fetch
    typedef enum logic [2:0] {
        K_ALU    = 3'd0,   // ADD/SUB/AND/OR : Rb->Y, Rc op Y->Z, Z->Ra
        K_ADDI   = 3'd1,   // as K_ALU with C in place of Rc
        K_MULDIV = 3'd2,   // Ra->Y, Rb op Y->Z, ZLow->LO, ZHigh->HI
        K_MFX    = 3'd3,   // HI/LO -> Ra
        K_LD     = 3'd4,
        K_ST     = 3'd5,
        K_NOP    = 3'd6,
        K_HALT   = 3'd7
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t k;
        case (op)
            c_op_add, c_op_sub, c_op_and, c_op_or: k = K_ALU;
            c_op_addi:                             k = K_ADDI;
            c_op_mul, c_op_div:                    k = K_MULDIV;
            c_op_mfhi, c_op_mflo:                  k = K_MFX;
            c_op_ld:                               k = K_LD;
            c_op_st:                               k = K_ST;
            c_op_halt:                             k = K_HALT;
            default:                               k = K_NOP;
        endcase
        return k;
    endfunction

    // ALU code used in the operate step of register-register instructions
    function automatic logic [4:0] alu_for(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            c_op_sub: a = c_alu_sub;
            c_op_and: a = c_alu_and;
            c_op_or:  a = c_alu_or;
            c_op_mul: a = c_alu_mul;
            c_op_div: a = c_alu_div;
            default:  a = c_alu_add;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Bundle between the control sequencer and the datapath.
//                master : the sequencer (takes start/ir/memReady, drives
//                         bus select, load strobes, memory requests, aluOp)
//                slave  : the datapath / memory side
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int NUM_REGS = 16
);
    logic                start;
    logic [31:0]         ir;
    logic                memReady;
    logic                busEn;
    logic [4:0]          busSel;
    logic [NUM_REGS-1:0] rIn;
    logic                pcIn;
    logic                irIn;
    logic                marIn;
    logic                mdrIn;
    logic                yIn;
    logic                zIn;
    logic                hiIn;
    logic                loIn;
    logic                memRead;
    logic                memWrite;
    logic [4:0]          aluOp;
    logic                run;

    modport master (
        input  start, ir, memReady,
        output busEn, busSel, rIn, pcIn, irIn, marIn, mdrIn, yIn, zIn,
               hiIn, loIn, memRead, memWrite, aluOp, run
    );

    modport slave (
        output start, ir, memReady,
        input  busEn, busSel, rIn, pcIn, irIn, marIn, mdrIn, yIn, zIn,
               hiIn, loIn, memRead, memWrite, aluOp, run
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_reg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : reg_decoder
//  Description : 4-to-NUM_REGS one-hot decoder with enable; produces the
//                general register load enables.
//  Ports       : en     - decode enable (all outputs 0 when low)
//                sel    - register index
//                onehot - one-hot load enable, at most one bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_decoder #(
    parameter int NUM_REGS = 16
) (
    input  wire logic                en,
    input  wire logic [3:0]          sel,
    output logic      [NUM_REGS-1:0] onehot
);
    // Each output bit compares the index independently, so no two bits can
    // ever be high together; indices beyond NUM_REGS-1 select nothing.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_onehot
        assign onehot[i] = en && ({28'd0, sel} == 32'(i));
    end
endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired control sequencer for a bus-based datapath.
//                Steps IDLE -> T0..T7 -> T0 per instruction, HALT parks until
//                reset. Outputs are a decode of the current step, the IR and
//                the first-cycle flag; memReady only gates the MDR load and
//                the advance out of memory wait steps.
//  Ports       : clock - rising-edge clock
//                clear - asynchronous active-low reset
//                bus   - control_sequencer_if.master (start, ir, memReady in;
//                        bus select, load strobes, memory requests, aluOp,
//                        run out)
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  wire logic           clock,
    input  wire logic           clear,
    control_sequencer_if.master bus
);

    state_t    r_state;
    logic      r_first;     // high during the first cycle spent in T1

    logic [4:0] w_op;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    op_class_t  w_class;

    assign w_op    = bus.ir[31:27];
    assign w_ra    = bus.ir[26:23];
    assign w_rb    = bus.ir[22:19];
    assign w_rc    = bus.ir[18:15];
    assign w_class = classify(w_op);

    // The immediate field is consumed by the datapath, not by the sequencer
    logic w_unused_imm;
    assign w_unused_imm = &{1'b0, bus.ir[14:0]};

    // ------------------------------------------------------------------
    // Step register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
        end else begin
            // T1 is only ever entered from T0
            r_first <= (r_state == S_T0);
            case (r_state)
                S_IDLE: if (bus.start) r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1:   if (bus.memReady) r_state <= S_T2;
                S_T2:   r_state <= (w_class == K_NOP) ? S_T0 : S_T3;
                S_T3: begin
                    case (w_class)
                        K_MFX:   r_state <= S_T0;
                        K_HALT:  r_state <= S_HALT;
                        K_NOP:   r_state <= S_T0;
                        default: r_state <= S_T4;
                    endcase
                end
                S_T4:   r_state <= S_T5;
                S_T5: begin
                    if (w_class == K_ALU || w_class == K_ADDI)
                        r_state <= S_T0;
                    else
                        r_state <= S_T6;
                end
                S_T6: begin
                    if (w_class == K_LD)
                        r_state <= bus.memReady ? S_T7 : S_T6;
                    else if (w_class == K_ST)
                        r_state <= S_T7;
                    else
                        r_state <= S_T0;
                end
                S_T7: begin
                    if (w_class == K_ST)
                        r_state <= bus.memReady ? S_T0 : S_T7;
                    else
                        r_state <= S_T0;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Every output defaults to 0; a step names only what it
    // drives, and busEn is set together with every busSel assignment.
    // ------------------------------------------------------------------
    logic       w_busen;
    logic [4:0] w_bussel;
    logic       w_reg_en;
    logic [3:0] w_reg_sel;
    logic       w_pcin, w_irin, w_marin, w_mdrin, w_yin, w_zin, w_hiin, w_loin;
    logic       w_memread, w_memwrite;
    logic [4:0] w_aluop;
    logic       w_run;

    always_comb begin
        w_busen    = 1'b0;
        w_bussel   = 5'd0;
        w_reg_en   = 1'b0;
        w_reg_sel  = 4'd0;
        w_pcin     = 1'b0;
        w_irin     = 1'b0;
        w_marin    = 1'b0;
        w_mdrin    = 1'b0;
        w_yin      = 1'b0;
        w_zin      = 1'b0;
        w_hiin     = 1'b0;
        w_loin     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_aluop    = 5'd0;
        w_run      = (r_state != S_IDLE) && (r_state != S_HALT);

        case (r_state)
            S_T0: begin
                w_busen  = 1'b1;
                w_bussel = c_bus_pc;
                w_marin  = 1'b1;
                w_aluop  = c_alu_inc;
                w_zin    = 1'b1;
            end
            S_T1: begin
                w_memread = 1'b1;
                // PC+1 is written back once, even if the read stalls
                if (r_first) begin
                    w_busen  = 1'b1;
                    w_bussel = c_bus_zlow;
                    w_pcin   = 1'b1;
                end
                w_mdrin = bus.memReady;
            end
            S_T2: begin
                w_busen  = 1'b1;
                w_bussel = c_bus_mdr;
                w_irin   = 1'b1;
            end
            S_T3: begin
                case (w_class)
                    K_ALU, K_ADDI, K_LD, K_ST: begin
                        w_busen  = 1'b1;
                        w_bussel = {1'b0, w_rb};
                        w_yin    = 1'b1;
                    end
                    K_MULDIV: begin
                        w_busen  = 1'b1;
                        w_bussel = {1'b0, w_ra};
                        w_yin    = 1'b1;
                    end
                    K_MFX: begin
                        w_busen   = 1'b1;
                        w_bussel  = (w_op == c_op_mfhi) ? c_bus_hi : c_bus_lo;
                        w_reg_en  = 1'b1;
                        w_reg_sel = w_ra;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_class)
                    K_ALU: begin
                        w_busen  = 1'b1;
                        w_bussel = {1'b0, w_rc};
                        w_aluop  = alu_for(w_op);
                        w_zin    = 1'b1;
                    end
                    K_MULDIV: begin
                        w_busen  = 1'b1;
                        w_bussel = {1'b0, w_rb};
                        w_aluop  = alu_for(w_op);
                        w_zin    = 1'b1;
                    end
                    K_ADDI, K_LD, K_ST: begin
                        w_busen  = 1'b1;
                        w_bussel = c_bus_c;
                        w_aluop  = c_alu_add;
                        w_zin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_class)
                    K_ALU, K_ADDI: begin
                        w_busen   = 1'b1;
                        w_bussel  = c_bus_zlow;
                        w_reg_en  = 1'b1;
                        w_reg_sel = w_ra;
                    end
                    K_MULDIV: begin
                        w_busen  = 1'b1;
                        w_bussel = c_bus_zlow;
                        w_loin   = 1'b1;
                    end
                    K_LD, K_ST: begin
                        w_busen  = 1'b1;
                        w_bussel = c_bus_zlow;
                        w_marin  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (w_class)
                    K_MULDIV: begin
                        w_busen  = 1'b1;
                        w_bussel = c_bus_zhigh;
                        w_hiin   = 1'b1;
                    end
                    K_LD: begin
                        w_memread = 1'b1;
                        w_mdrin   = bus.memReady;
                    end
                    K_ST: begin
                        w_busen  = 1'b1;
                        w_bussel = {1'b0, w_ra};
                        w_mdrin  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (w_class)
                    K_LD: begin
                        w_busen   = 1'b1;
                        w_bussel  = c_bus_mdr;
                        w_reg_en  = 1'b1;
                        w_reg_sel = w_ra;
                    end
                    K_ST: w_memwrite = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    logic [NUM_REGS-1:0] w_rin;

    reg_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_decoder (
        .en     (w_reg_en),
        .sel    (w_reg_sel),
        .onehot (w_rin)
    );

    assign bus.busEn    = w_busen;
    assign bus.busSel   = w_bussel;
    assign bus.rIn      = w_rin;
    assign bus.pcIn     = w_pcin;
    assign bus.irIn     = w_irin;
    assign bus.marIn    = w_marin;
    assign bus.mdrIn    = w_mdrin;
    assign bus.yIn      = w_yin;
    assign bus.zIn      = w_zin;
    assign bus.hiIn     = w_hiin;
    assign bus.loIn     = w_loin;
    assign bus.memRead  = w_memread;
    assign bus.memWrite = w_memwrite;
    assign bus.aluOp    = w_aluop;
    assign bus.run      = w_run;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer. A table of
//                per-cycle {start, ir, memReady, expected outputs} records
//                walks a chain of instructions; hand-written sequences cover
//                memory waits, HALT and asynchronous clear.
//                Output vector layout (38 bits):
//                {run, busEn, busSel[4:0], rIn[15:0],
//                 pcIn, irIn, marIn, mdrIn, yIn, zIn, hiIn, loIn,
//                 memRead, memWrite, aluOp[4:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam logic [7:0] P  = 8'h80;  // pcIn
    localparam logic [7:0] I  = 8'h40;  // irIn
    localparam logic [7:0] MA = 8'h20;  // marIn
    localparam logic [7:0] MD = 8'h10;  // mdrIn
    localparam logic [7:0] Y  = 8'h08;  // yIn
    localparam logic [7:0] Z  = 8'h04;  // zIn
    localparam logic [7:0] H  = 8'h02;  // hiIn
    localparam logic [7:0] L  = 8'h01;  // loIn
    localparam logic [7:0] N  = 8'h00;

    logic clk;
    logic clear;
    int   checks;
    int   errors;

    control_sequencer_if #(.NUM_REGS(16)) bus ();

    control_sequencer #(.NUM_REGS(16)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [31:0] ir;
        logic        mr;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        logic [31:0] r;
        r        = 32'h0000_1234;
        r[31:27] = op[4:0];
        r[26:23] = ra[3:0];
        r[22:19] = rb[3:0];
        r[18:15] = rc[3:0];
        return r;
    endfunction

    function automatic logic [37:0] ex(input bit run, input bit ben, input int sel,
                                       input int rin, input logic [7:0] strb,
                                       input bit rd, input bit wr, input int alu);
        return {run, ben, sel[4:0], rin[15:0], strb, rd, wr, alu[4:0]};
    endfunction

    function automatic logic [37:0] outv();
        return {bus.run, bus.busEn, bus.busSel, bus.rIn,
                bus.pcIn, bus.irIn, bus.marIn, bus.mdrIn,
                bus.yIn, bus.zIn, bus.hiIn, bus.loIn,
                bus.memRead, bus.memWrite, bus.aluOp};
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic add(input logic st, input logic [31:0] ir, input logic mr, input logic [37:0] e);
        vecs.push_back('{st, ir, mr, e});
    endtask

    // T0, T1 (memReady high, first cycle), T2
    task automatic fetch(input logic [31:0] ir, input logic st);
        add(st,   ir, 1'b1, ex(1, 1, 20, 0, MA | Z, 0, 0, 6));
        add(1'b0, ir, 1'b1, ex(1, 1, 19, 0, P | MD, 1, 0, 0));
        add(1'b0, ir, 1'b1, ex(1, 1, 21, 0, I,      0, 0, 0));
    endtask

    // One clock: drive after the falling edge, sample 1 time unit later
    task automatic cyc(input logic st, input logic mr);
        @(negedge clk);
        bus.start    = st;
        bus.memReady = mr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear        = 1'b0;
        bus.start    = 1'b0;
        bus.memReady = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
    endtask

    initial begin
        logic [31:0] i_add, i_mul, i_addi, i_ld, i_sub, i_mfhi, i_nop20;
        logic [31:0] i_mflo, i_div, i_or, i_and, i_nop, i_st, i_halt;
        int n_rd, n_wr, n_pc, n_mdr, n_bad;

        checks = 0;
        errors = 0;
        clear        = 1'b0;
        bus.start    = 1'b1;
        bus.ir       = 32'd0;
        bus.memReady = 1'b1;

        i_add   = mk(0, 1, 2, 3);
        i_mul   = mk(7, 4, 5, 0);
        i_addi  = mk(6, 7, 8, 0);
        i_ld    = mk(4, 9, 10, 0);
        i_sub   = mk(1, 0, 15, 14);
        i_mfhi  = mk(9, 5, 0, 0);
        i_nop20 = mk(20, 1, 1, 1);
        i_mflo  = mk(10, 3, 0, 0);
        i_div   = mk(8, 1, 2, 0);
        i_or    = mk(3, 2, 4, 6);
        i_and   = mk(2, 15, 1, 2);
        i_nop   = mk(11, 0, 0, 0);
        i_st    = mk(5, 6, 1, 0);
        i_halt  = mk(12, 0, 0, 0);

        // ---------------- vector table ----------------
        add(1'b1, i_add, 1'b1, ex(0, 0, 0, 0, N, 0, 0, 0));           // IDLE + start
        fetch(i_add, 1'b0);
        add(1'b0, i_add, 1'b1, ex(1, 1, 2,  0,      Y, 0, 0, 0));
        add(1'b0, i_add, 1'b1, ex(1, 1, 3,  0,      Z, 0, 0, 0));
        add(1'b0, i_add, 1'b1, ex(1, 1, 19, 16'h2,  N, 0, 0, 0));
        fetch(i_mul, 1'b0);
        add(1'b0, i_mul, 1'b1, ex(1, 1, 4,  0, Y, 0, 0, 0));
        add(1'b0, i_mul, 1'b1, ex(1, 1, 5,  0, Z, 0, 0, 4));
        add(1'b0, i_mul, 1'b1, ex(1, 1, 19, 0, L, 0, 0, 0));
        add(1'b0, i_mul, 1'b1, ex(1, 1, 18, 0, H, 0, 0, 0));
        fetch(i_addi, 1'b0);
        add(1'b0, i_addi, 1'b1, ex(1, 1, 8,  0,     Y, 0, 0, 0));
        add(1'b0, i_addi, 1'b1, ex(1, 1, 23, 0,     Z, 0, 0, 0));
        add(1'b0, i_addi, 1'b1, ex(1, 1, 19, 16'h80, N, 0, 0, 0));
        fetch(i_ld, 1'b1);                                           // start outside IDLE
        add(1'b0, i_ld, 1'b1, ex(1, 1, 10, 0,      Y,  0, 0, 0));
        add(1'b0, i_ld, 1'b1, ex(1, 1, 23, 0,      Z,  0, 0, 0));
        add(1'b0, i_ld, 1'b1, ex(1, 1, 19, 0,      MA, 0, 0, 0));
        add(1'b0, i_ld, 1'b0, ex(1, 0, 0,  0,      N,  1, 0, 0));    // T6 wait
        add(1'b0, i_ld, 1'b1, ex(1, 0, 0,  0,      MD, 1, 0, 0));
        add(1'b0, i_ld, 1'b1, ex(1, 1, 21, 16'h200, N, 0, 0, 0));
        fetch(i_sub, 1'b0);
        add(1'b0, i_sub, 1'b1, ex(1, 1, 15, 0,   Y, 0, 0, 0));
        add(1'b0, i_sub, 1'b1, ex(1, 1, 14, 0,   Z, 0, 0, 1));
        add(1'b0, i_sub, 1'b1, ex(1, 1, 19, 16'h1, N, 0, 0, 0));
        fetch(i_mfhi, 1'b0);
        add(1'b0, i_mfhi, 1'b1, ex(1, 1, 16, 16'h20, N, 0, 0, 0));
        fetch(i_nop20, 1'b0);                                        // unassigned opcode
        fetch(i_mflo, 1'b0);
        add(1'b0, i_mflo, 1'b1, ex(1, 1, 17, 16'h8, N, 0, 0, 0));
        fetch(i_div, 1'b0);
        add(1'b0, i_div, 1'b0, ex(1, 1, 1,  0, Y, 0, 0, 0));         // memReady low ignored
        add(1'b0, i_div, 1'b0, ex(1, 1, 2,  0, Z, 0, 0, 5));
        add(1'b0, i_div, 1'b1, ex(1, 1, 19, 0, L, 0, 0, 0));
        add(1'b0, i_div, 1'b1, ex(1, 1, 18, 0, H, 0, 0, 0));
        fetch(i_or, 1'b0);
        add(1'b0, i_or, 1'b1, ex(1, 1, 4,  0,     Y, 0, 0, 0));
        add(1'b0, i_or, 1'b1, ex(1, 1, 6,  0,     Z, 0, 0, 3));
        add(1'b0, i_or, 1'b1, ex(1, 1, 19, 16'h4, N, 0, 0, 0));
        fetch(i_and, 1'b0);
        add(1'b0, i_and, 1'b1, ex(1, 1, 1,  0,        Y, 0, 0, 0));
        add(1'b0, i_and, 1'b1, ex(1, 1, 2,  0,        Z, 0, 0, 2));
        add(1'b0, i_and, 1'b1, ex(1, 1, 19, 16'h8000, N, 0, 0, 0));
        fetch(i_nop, 1'b0);
        fetch(i_nop, 1'b0);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", outv(), ex(0, 0, 0, 0, N, 0, 0, 0));
        @(negedge clk);
        clear = 1'b1;
        bus.start = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            bus.start    = vecs[k].start;
            bus.ir       = vecs[k].ir;
            bus.memReady = vecs[k].mr;
            #1;
            check($sformatf("vec%0d", k), outv(), vecs[k].exp);
        end

        // ---------------- fetch with 3-cycle memory wait ----------------
        do_reset();
        bus.ir = i_nop;
        cyc(1'b1, 1'b0);
        n_rd = 0; n_pc = 0; n_mdr = 0; n_bad = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, k == 4);              // T0, T1 x4 (ready on last), T2
            if (bus.memRead) n_rd++;
            if (bus.pcIn)    n_pc++;
            if (bus.mdrIn)   n_mdr++;
            if (bus.mdrIn && !bus.memReady) n_bad++;
        end
        check_int("fetchwait_memread_cycles", n_rd, 4);
        check_int("fetchwait_pcin_pulses", n_pc, 1);
        check_int("fetchwait_mdrin_pulses", n_mdr, 1);
        check_int("fetchwait_mdrin_without_ready", n_bad, 0);
        cyc(1'b0, 1'b0);
        check("fetchwait_back_to_t0", outv(), ex(1, 1, 20, 0, MA | Z, 0, 0, 6));

        // ---------------- ST R6 with 2-cycle write wait ----------------
        do_reset();
        bus.ir = i_st;
        cyc(1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b1);         // T0..T5
        cyc(1'b0, 1'b0);                    // T6: must not wait on memReady
        check("st_t6", outv(), ex(1, 1, 6, 0, MD, 0, 0, 0));
        n_rd = 0; n_wr = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, k == 2);
            if (bus.memWrite) n_wr++;
            if (bus.memRead)  n_rd++;
        end
        check_int("st_memwrite_cycles", n_wr, 3);
        check_int("st_memread_in_t7", n_rd, 0);
        cyc(1'b0, 1'b1);
        check("st_back_to_t0", outv(), ex(1, 1, 20, 0, MA | Z, 0, 0, 6));

        // ---------------- HALT ----------------
        do_reset();
        bus.ir = i_halt;
        cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1);         // T0..T2
        cyc(1'b0, 1'b1);
        check("halt_t3", outv(), ex(1, 0, 0, 0, N, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            cyc(k == 1, 1'b1);
            check($sformatf("halt_parked%0d", k), outv(), ex(0, 0, 0, 0, N, 0, 0, 0));
        end
        do_reset();
        bus.ir = i_add;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        check("halt_resume_t0", outv(), ex(1, 1, 20, 0, MA | Z, 0, 0, 6));

        // ---------------- clear during T1 wait ----------------
        do_reset();
        bus.ir = i_add;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);                    // T0
        cyc(1'b0, 1'b0);                    // T1 first cycle
        check("t1_first_wait", outv(), ex(1, 1, 19, 0, P, 1, 0, 0));
        cyc(1'b0, 1'b0);                    // T1 second cycle
        check("t1_second_wait", outv(), ex(1, 0, 0, 0, N, 1, 0, 0));
        #2;
        clear = 1'b0;                       // mid-cycle, away from any edge
        #1;
        check("clear_mid_t1", outv(), ex(0, 0, 0, 0, N, 0, 0, 0));
        @(negedge clk);
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1);
            check($sformatf("idle_needs_start%0d", k), outv(), ex(0, 0, 0, 0, N, 0, 0, 0));
        end
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        check("clear_restart_t0", outv(), ex(1, 1, 20, 0, MA | Z, 0, 0, 6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
